msx_ps2_keymatrix: RTL and testbench

- Converts the PS/2 scancode byte stream into the MSX 11-row x 8-column keyboard matrix.
- Supplies the column byte the PPI reads on port B for the row it drives on port C[3:0].
- Sits between the PS/2 byte receiver and the jt8255 PPI: row_sel is taken from portc_dout[3:0] and cols_n drives portb_din.
- Holds per-key state and decodes make, break, E0 (extended), F0 (break) and E1 (pause) sequences.

---
 rtl/msx_ps2_keymatrix_pkg.sv | 33 +++
 rtl/msx_ps2_keymatrix_if.sv | 14 +
 rtl/msx_ps2_keymatrix_keymap.sv | 63 ++++++
 rtl/msx_ps2_keymatrix.sv | 98 +++++++++
 tb/tb_msx_ps2_keymatrix.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/msx_ps2_keymatrix_pkg.sv
// Shared constants and types for the PS/2-to-MSX keyboard matrix bridge.
// Scancode prefixes, matrix dimensions and the keymap lookup result.
package msx_kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  localparam int MTX_ROWS = 11;
  localparam int MTX_COLS = 8;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } keymap_t;

  typedef enum logic {ST_IDLE, ST_SKIP} dec_state_t;

  function automatic keymap_t key_at(input logic [3:0] r, input logic [2:0] c);
    keymap_t k;
    k.hit = 1'b1;
    k.row = r;
    k.col = c;
    return k;
  endfunction

endpackage

// File: rtl/msx_ps2_keymatrix_if.sv
// Byte stream in, PPI row/column read path out, plus event pulses.
interface msx_ps2_keymatrix_if;
  logic [7:0] ps2_code;
  logic       ps2_valid;
  logic [3:0] row_sel;
  logic [7:0] cols_n;
  logic       key_event;
  logic       overrun;

  modport master (output ps2_code, ps2_valid, row_sel,
                  input  cols_n, key_event, overrun);
  modport slave  (input  ps2_code, ps2_valid, row_sel,
                  output cols_n, key_event, overrun);
endinterface

// File: rtl/msx_ps2_keymatrix_keymap.sv
// Combinational {ext, code} -> matrix position table, MSX international layout.
// Kept on its own so another layout can be dropped in without touching the decoder.
module msx_keymap
  import msx_kbd_pkg::*;
(
  input  logic [8:0] key_i,
  output keymap_t    map_o
);

  always_comb begin
    map_o = '0;
    case (key_i)
      9'h045: map_o = key_at(4'd0, 3'd0);  9'h016: map_o = key_at(4'd0, 3'd1);
      9'h01E: map_o = key_at(4'd0, 3'd2);  9'h026: map_o = key_at(4'd0, 3'd3);
      9'h025: map_o = key_at(4'd0, 3'd4);  9'h02E: map_o = key_at(4'd0, 3'd5);
      9'h036: map_o = key_at(4'd0, 3'd6);  9'h03D: map_o = key_at(4'd0, 3'd7);
      9'h03E: map_o = key_at(4'd1, 3'd0);  9'h046: map_o = key_at(4'd1, 3'd1);
      9'h04E: map_o = key_at(4'd1, 3'd2);  9'h055: map_o = key_at(4'd1, 3'd3);
      9'h05D: map_o = key_at(4'd1, 3'd4);  9'h054: map_o = key_at(4'd1, 3'd5);
      9'h05B: map_o = key_at(4'd1, 3'd6);  9'h04C: map_o = key_at(4'd1, 3'd7);
      9'h052: map_o = key_at(4'd2, 3'd0);  9'h00E: map_o = key_at(4'd2, 3'd1);
      9'h041: map_o = key_at(4'd2, 3'd2);  9'h049: map_o = key_at(4'd2, 3'd3);
      9'h04A: map_o = key_at(4'd2, 3'd4);  9'h061: map_o = key_at(4'd2, 3'd5);
      9'h01C: map_o = key_at(4'd2, 3'd6);  9'h032: map_o = key_at(4'd2, 3'd7);
      9'h021: map_o = key_at(4'd3, 3'd0);  9'h023: map_o = key_at(4'd3, 3'd1);
      9'h024: map_o = key_at(4'd3, 3'd2);  9'h02B: map_o = key_at(4'd3, 3'd3);
      9'h034: map_o = key_at(4'd3, 3'd4);  9'h033: map_o = key_at(4'd3, 3'd5);
      9'h043: map_o = key_at(4'd3, 3'd6);  9'h03B: map_o = key_at(4'd3, 3'd7);
      9'h042: map_o = key_at(4'd4, 3'd0);  9'h04B: map_o = key_at(4'd4, 3'd1);
      9'h03A: map_o = key_at(4'd4, 3'd2);  9'h031: map_o = key_at(4'd4, 3'd3);
      9'h044: map_o = key_at(4'd4, 3'd4);  9'h04D: map_o = key_at(4'd4, 3'd5);
      9'h015: map_o = key_at(4'd4, 3'd6);  9'h02D: map_o = key_at(4'd4, 3'd7);
      9'h01B: map_o = key_at(4'd5, 3'd0);  9'h02C: map_o = key_at(4'd5, 3'd1);
      9'h03C: map_o = key_at(4'd5, 3'd2);  9'h02A: map_o = key_at(4'd5, 3'd3);
      9'h01D: map_o = key_at(4'd5, 3'd4);  9'h022: map_o = key_at(4'd5, 3'd5);
      9'h035: map_o = key_at(4'd5, 3'd6);  9'h01A: map_o = key_at(4'd5, 3'd7);
      9'h012: map_o = key_at(4'd6, 3'd0);  9'h059: map_o = key_at(4'd6, 3'd0);
      9'h014: map_o = key_at(4'd6, 3'd1);  9'h114: map_o = key_at(4'd6, 3'd1);
      9'h011: map_o = key_at(4'd6, 3'd2);  9'h058: map_o = key_at(4'd6, 3'd3);
      9'h111: map_o = key_at(4'd6, 3'd4);  9'h005: map_o = key_at(4'd6, 3'd5);
      9'h006: map_o = key_at(4'd6, 3'd6);  9'h004: map_o = key_at(4'd6, 3'd7);
      9'h00C: map_o = key_at(4'd7, 3'd0);  9'h003: map_o = key_at(4'd7, 3'd1);
      9'h076: map_o = key_at(4'd7, 3'd2);  9'h00D: map_o = key_at(4'd7, 3'd3);
      9'h00A: map_o = key_at(4'd7, 3'd4);  9'h066: map_o = key_at(4'd7, 3'd5);
      9'h001: map_o = key_at(4'd7, 3'd6);  9'h05A: map_o = key_at(4'd7, 3'd7);
      9'h15A: map_o = key_at(4'd7, 3'd7);
      9'h029: map_o = key_at(4'd8, 3'd0);  9'h16C: map_o = key_at(4'd8, 3'd1);
      9'h170: map_o = key_at(4'd8, 3'd2);  9'h171: map_o = key_at(4'd8, 3'd3);
      9'h16B: map_o = key_at(4'd8, 3'd4);  9'h175: map_o = key_at(4'd8, 3'd5);
      9'h172: map_o = key_at(4'd8, 3'd6);  9'h174: map_o = key_at(4'd8, 3'd7);
      9'h07C: map_o = key_at(4'd9, 3'd0);  9'h079: map_o = key_at(4'd9, 3'd1);
      9'h14A: map_o = key_at(4'd9, 3'd2);  9'h070: map_o = key_at(4'd9, 3'd3);
      9'h069: map_o = key_at(4'd9, 3'd4);  9'h072: map_o = key_at(4'd9, 3'd5);
      9'h07A: map_o = key_at(4'd9, 3'd6);  9'h06B: map_o = key_at(4'd9, 3'd7);
      9'h073: map_o = key_at(4'd10, 3'd0); 9'h074: map_o = key_at(4'd10, 3'd1);
      9'h075: map_o = key_at(4'd10, 3'd2); 9'h06C: map_o = key_at(4'd10, 3'd3);
      9'h07D: map_o = key_at(4'd10, 3'd4); 9'h07B: map_o = key_at(4'd10, 3'd5);
      9'h071: map_o = key_at(4'd10, 3'd7);
      default: map_o = '0;
    endcase
  end

endmodule

// File: rtl/msx_ps2_keymatrix.sv
// PS/2 scancode decoder driving the MSX key matrix and the PPI column read register.
// ST_IDLE: collecting prefixes / applying keys | ST_SKIP: discarding the bytes of a pause sequence
module msx_ps2_keymatrix
  import msx_kbd_pkg::*;
#(
  parameter int ROWS       = MTX_ROWS,
  parameter int PAUSE_SKIP = 7
) (
  input  logic                clk,
  input  logic                rst,
  msx_ps2_keymatrix_if.slave  bus
);

  localparam int         SKW    = $clog2(PAUSE_SKIP + 1);
  localparam logic [4:0] ROWS_L = 5'(ROWS);

  dec_state_t                        state_q;
  logic                              ext_q, brk_q;
  logic [SKW-1:0]                    skip_q;
  logic [ROWS-1:0][MTX_COLS-1:0]     mtx_q;
  logic [7:0]                        cols_n_q;
  logic                              key_event_q, overrun_q;
  keymap_t                           key_map;
  logic                              row_ok;

  msx_keymap u_keymap (
    .key_i ({ext_q, bus.ps2_code}),
    .map_o (key_map)
  );

  assign row_ok = ({1'b0, bus.row_sel} < ROWS_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= '0;
      mtx_q       <= '1;
      cols_n_q    <= 8'hFF;
      key_event_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      key_event_q <= 1'b0;
      overrun_q   <= 1'b0;
      // Reads the pre-write matrix, so a same-cycle write shows up one cycle later.
      cols_n_q    <= row_ok ? mtx_q[bus.row_sel] : 8'hFF;
      if (bus.ps2_valid) begin
        case (state_q)
          ST_IDLE: begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            case (bus.ps2_code)
              SC_EXT: begin
                ext_q <= 1'b1;
                brk_q <= brk_q;
              end
              SC_BRK: begin
                brk_q <= 1'b1;
                ext_q <= ext_q;
              end
              SC_PAUSE: begin
                state_q <= ST_SKIP;
                skip_q  <= SKW'(PAUSE_SKIP);
              end
              SC_ERR0, SC_ERR1: begin
                mtx_q       <= '1;
                overrun_q   <= 1'b1;
                key_event_q <= ~&mtx_q;
              end
              SC_BAT, SC_ACK, SC_RESEND: ;
              default: begin
                if (key_map.hit && ({1'b0, key_map.row} < ROWS_L) &&
                    (mtx_q[key_map.row][key_map.col] != brk_q)) begin
                  mtx_q[key_map.row][key_map.col] <= brk_q;
                  key_event_q                     <= 1'b1;
                end
              end
            endcase
          end
          ST_SKIP: begin
            skip_q <= skip_q - SKW'(1);
            if (skip_q <= SKW'(1)) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cols_n    = cols_n_q;
  assign bus.key_event = key_event_q;
  assign bus.overrun   = overrun_q;

  a_keymap_range: assert property (@(posedge clk) disable iff (rst)
    key_map.hit |-> ({1'b0, key_map.row} < ROWS_L));

endmodule

// File: tb/tb_msx_ps2_keymatrix.sv
// Directed plus randomized byte streams against a per-key behavioural model of the MSX matrix.
module tb_msx_ps2_keymatrix;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msx_ps2_keymatrix_if bus ();

  msx_ps2_keymatrix #(.ROWS(11), .PAUSE_SKIP(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] m_row [16];
  int         m_skip;
  bit         m_ext, m_brk;
  logic [3:0] cur_row = 4'd0;

  // Only the keys the random pool can produce; positions taken from the MSX layout.
  function automatic bit lookup(input bit e, input logic [7:0] c, output int r, output int k);
    r = 0; k = 0;
    case ({e, c})
      9'h01C: begin r = 2;  k = 6; end
      9'h032: begin r = 2;  k = 7; end
      9'h012: begin r = 6;  k = 0; end
      9'h021: begin r = 3;  k = 0; end
      9'h015: begin r = 4;  k = 6; end
      9'h01A: begin r = 5;  k = 7; end
      9'h045: begin r = 0;  k = 0; end
      9'h03D: begin r = 0;  k = 7; end
      9'h029: begin r = 8;  k = 0; end
      9'h05A: begin r = 7;  k = 7; end
      9'h15A: begin r = 7;  k = 7; end
      9'h075: begin r = 10; k = 2; end
      9'h175: begin r = 8;  k = 5; end
      9'h072: begin r = 9;  k = 5; end
      9'h172: begin r = 8;  k = 6; end
      9'h06B: begin r = 9;  k = 7; end
      9'h16B: begin r = 8;  k = 4; end
      9'h07C: begin r = 9;  k = 0; end
      9'h071: begin r = 10; k = 7; end
      9'h171: begin r = 8;  k = 3; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_row[i] = 8'hFF;
    m_skip = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] c, output bit ke, output bit ov);
    int r, k;
    ke = 0; ov = 0;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else begin
      if (c == 8'hE1) m_skip = 7;
      else if (c == 8'h00 || c == 8'hFF) begin
        ov = 1;
        for (int i = 0; i < 16; i++) begin
          if (m_row[i] != 8'hFF) ke = 1;
          m_row[i] = 8'hFF;
        end
      end else if (c == 8'hAA || c == 8'hFA || c == 8'hFE) begin
      end else if (lookup(m_ext, c, r, k)) begin
        if (m_row[r][k] != m_brk) begin
          ke = 1;
          m_row[r][k] = m_brk;
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check what the rising edge produced.
  task automatic step(input bit v, input logic [7:0] c, input logic [3:0] r);
    bit eke, eov;
    logic [7:0] ecols;
    bus.ps2_valid = v; bus.ps2_code = c; bus.row_sel = r;
    ecols = m_row[r];
    eke = 0; eov = 0;
    if (v) model_byte(c, eke, eov);
    @(negedge clk);
    chk("cols_n", bus.cols_n, ecols);
    chk("key_event", {7'd0, bus.key_event}, {7'd0, eke});
    chk("overrun", {7'd0, bus.overrun}, {7'd0, eov});
  endtask

  task automatic send(input logic [7:0] c, input bit exp_ke);
    step(1'b1, c, cur_row);
    chk("key_event_dir", {7'd0, bus.key_event}, {7'd0, exp_ke});
  endtask

  task automatic rd(input logic [3:0] r, input logic [7:0] exp, input string tag);
    cur_row = r;
    step(1'b0, 8'h00, r);
    chk(tag, bus.cols_n, exp);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.ps2_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [7:0] pool [29] = '{8'h1C, 8'h12, 8'h32, 8'h21, 8'h15, 8'h1A, 8'h45, 8'h3D,
                            8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h7C, 8'h71, 8'h7E,
                            8'h84, 8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1,
                            8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};

  initial begin
    bus.ps2_code = 8'h00; bus.ps2_valid = 1'b0; bus.row_sel = 4'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cols", bus.cols_n, 8'hFF);
    chk("rst_key_event", {7'd0, bus.key_event}, 8'h00);
    chk("rst_overrun", {7'd0, bus.overrun}, 8'h00);
    rst = 1'b0;
    model_reset();

    for (int r = 0; r < 16; r++) rd(4'(r), 8'hFF, "sweep");

    rd(4'd2, 8'hFF, "row2_idle");
    send(8'h1C, 1); rd(4'd2, 8'hBF, "a_make");
    send(8'hF0, 0); send(8'h1C, 1); rd(4'd2, 8'hFF, "a_break");
    send(8'h1C, 1); send(8'h1C, 0); send(8'h1C, 0); rd(4'd2, 8'hBF, "a_typematic");

    send(8'hE0, 0); send(8'h75, 1); rd(4'd8, 8'hDF, "up_make");
    send(8'hF0, 0); send(8'hE0, 0); send(8'h75, 1); rd(4'd8, 8'hFF, "up_break");
    send(8'hE0, 0); send(8'h12, 0); rd(4'd8, 8'hFF, "fake_shift8"); rd(4'd6, 8'hFF, "fake_shift6");

    send(8'h12, 1);
    send(8'hFF, 1);
    chk("ff_overrun", {7'd0, bus.overrun}, 8'h01);
    rd(4'd2, 8'hFF, "ff_row2"); rd(4'd6, 8'hFF, "ff_row6");
    send(8'hFF, 0);
    chk("ff_again_overrun", {7'd0, bus.overrun}, 8'h01);

    foreach (pool[i]) if (i < 0) $fatal(1, "unreachable");
    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
    send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 0);
    send(8'h1C, 1); rd(4'd2, 8'hBF, "pause_a"); rd(4'd6, 8'hFF, "pause_ctrl");
    send(8'hF0, 0); send(8'h1C, 1);

    send(8'hE0, 0);
    do_reset(2);
    rd(4'd10, 8'hFF, "post_rst10");
    send(8'h75, 1); rd(4'd10, 8'hFB, "kp8_row10"); rd(4'd8, 8'hFF, "kp8_row8");
    send(8'hF0, 0); send(8'h75, 1);

    rd(4'd2, 8'hFF, "same_pre");
    send(8'h1C, 1);
    chk("same_old", bus.cols_n, 8'hFF);
    rd(4'd2, 8'hBF, "same_new");
    send(8'h00, 1);
    chk("zero_overrun", {7'd0, bus.overrun}, 8'h01);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(3) != 0, pool[$urandom_range(28)], 4'($urandom_range(15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
